// File: rtl/reg_file_sb.sv
//==============================================================================
// Module   : reg_file_sb
// Brief    : 2-read/1-write register file with write-to-read bypass, optional
//            hardwired-zero register 0 and a per-register busy scoreboard.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_ready1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_ready2,
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int c_DEPTH = 1 << ADDR_W;
   localparam int c_NPORT = 2;

   logic [DATA_W-1:0] r_regs [c_DEPTH];
   logic [c_DEPTH-1:0] r_busy;
   logic [ADDR_W:0]    r_busyCnt;

   logic               w_wrTake;
   logic               w_allocTake;
   logic [c_DEPTH-1:0] w_busyNext;
   logic [ADDR_W:0]    w_cntNext;

   logic [ADDR_W-1:0]  w_rdAddr  [c_NPORT];
   logic [DATA_W-1:0]  w_rdData  [c_NPORT];
   logic               w_rdReady [c_NPORT];

   // Register 0 is inert when hardwired to zero: no writes, no allocations.
   assign w_wrTake    = wr_en    && !(ZERO_REG && (wr_addr    == '0));
   assign w_allocTake = alloc_en && !(ZERO_REG && (alloc_addr == '0));

   // Alloc is applied after the write clear so a same-address alloc wins.
   always_comb begin
      w_busyNext = r_busy;
      if (w_wrTake) begin
         w_busyNext[wr_addr] = 1'b0;
      end
      if (w_allocTake) begin
         w_busyNext[alloc_addr] = 1'b1;
      end
   end

   always_comb begin
      w_cntNext = '0;
      for (int i = 0; i < c_DEPTH; i++) begin
         w_cntNext = w_cntNext + (ADDR_W+1)'(w_busyNext[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wrTake) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= '0;
         r_busyCnt <= '0;
      end else begin
         r_busy    <= w_busyNext;
         r_busyCnt <= w_cntNext;
      end
   end

   assign busy_cnt = r_busyCnt;

   assign w_rdAddr[0] = rd_addr1;
   assign w_rdAddr[1] = rd_addr2;

   generate
      for (genvar p = 0; p < c_NPORT; p++) begin : g_rdPort
         always_comb begin
            w_rdData[p]  = r_regs[w_rdAddr[p]];
            w_rdReady[p] = ~r_busy[w_rdAddr[p]];
            if (ZERO_REG && (w_rdAddr[p] == '0)) begin
               w_rdData[p]  = '0;
               w_rdReady[p] = 1'b1;
            end else if (wr_en && (wr_addr == w_rdAddr[p])) begin
               // Result being written this cycle is forwarded straight through.
               w_rdData[p]  = wr_data;
               w_rdReady[p] = 1'b1;
            end
         end
      end
   endgenerate

   assign rd_data1  = w_rdData[0];
   assign rd_ready1 = w_rdReady[0];
   assign rd_data2  = w_rdData[1];
   assign rd_ready2 = w_rdReady[1];

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sb.sv
//==============================================================================
// Module   : tb_reg_file_sb
// Brief    : Directed self-checking bench for reg_file_sb (32x32, zero reg on).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reg_file_sb;

   localparam int c_DW = 32;
   localparam int c_AW = 5;

   logic            clk;
   logic            rst_n;
   logic            wr_en;
   logic [c_AW-1:0] wr_addr;
   logic [c_DW-1:0] wr_data;
   logic [c_AW-1:0] rd_addr1;
   logic [c_DW-1:0] rd_data1;
   logic            rd_ready1;
   logic [c_AW-1:0] rd_addr2;
   logic [c_DW-1:0] rd_data2;
   logic            rd_ready2;
   logic            alloc_en;
   logic [c_AW-1:0] alloc_addr;
   logic [c_AW:0]   busy_cnt;

   int nAsserts = 0;
   int nFails   = 0;

   reg_file_sb #(.DATA_W(c_DW), .ADDR_W(c_AW), .ZERO_REG(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr1   (rd_addr1),
      .rd_data1   (rd_data1),
      .rd_ready1  (rd_ready1),
      .rd_addr2   (rd_addr2),
      .rd_data2   (rd_data2),
      .rd_ready2  (rd_ready2),
      .alloc_en   (alloc_en),
      .alloc_addr (alloc_addr),
      .busy_cnt   (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr1 = '0; rd_addr2 = 5'd5; alloc_en = 1'b0; alloc_addr = '0;

      // Reset state
      #12;
      chk("rst_cnt",    32'(busy_cnt), 32'd0);
      chk("rst_rd1",    rd_data1, 32'd0);
      chk("rst_rd2",    rd_data2, 32'd0);
      chk("rst_rdy2",   32'(rd_ready2), 32'd1);
      @(negedge clk); rst_n = 1'b1;

      // 1. Write regs 1..9 with 2*addr, read adjacent pairs
      for (int a = 1; a <= 9; a++) begin
         @(negedge clk);
         wr_en = 1'b1; wr_addr = 5'(a); wr_data = 32'(2*a);
      end
      @(negedge clk); wr_en = 1'b0;
      for (int a = 1; a <= 8; a++) begin
         rd_addr1 = 5'(a); rd_addr2 = 5'(a+1);
         #1;
         chk("pair_d1", rd_data1, 32'(2*a));
         chk("pair_d2", rd_data2, 32'(2*a+2));
         chk("pair_r1", 32'(rd_ready1), 32'd1);
         chk("pair_r2", 32'(rd_ready2), 32'd1);
      end

      // 2. Zero register ignores writes and allocs
      @(negedge clk);
      wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF; rd_addr1 = '0; rd_addr2 = '0;
      #1;
      chk("z_byp_d1", rd_data1, 32'd0);
      chk("z_byp_d2", rd_data2, 32'd0);
      @(negedge clk); wr_en = 1'b0;
      #1;
      chk("z_d1", rd_data1, 32'd0);
      chk("z_d2", rd_data2, 32'd0);
      chk("z_r1", 32'(rd_ready1), 32'd1);
      @(negedge clk); alloc_en = 1'b1; alloc_addr = '0;
      @(posedge clk); #1;
      chk("z_alloc_cnt", 32'(busy_cnt), 32'd0);
      @(negedge clk); alloc_en = 1'b0;
      #1;
      chk("z_alloc_rdy", 32'(rd_ready1), 32'd1);

      // 3. Bypass on reg 5 (holds 10)
      rd_addr1 = 5'd5; #1;
      chk("byp_old", rd_data1, 32'd10);
      @(negedge clk); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd77;
      #1;
      chk("byp_d1", rd_data1, 32'd77);
      chk("byp_r1", 32'(rd_ready1), 32'd1);
      @(negedge clk); wr_en = 1'b0;
      #1;
      chk("byp_after", rd_data1, 32'd77);

      // 4. Scoreboard: alloc 3, 4, 3 then write 3
      @(negedge clk); alloc_en = 1'b1; alloc_addr = 5'd3;
      @(posedge clk); #1; chk("sb_cnt1", 32'(busy_cnt), 32'd1);
      @(negedge clk); alloc_addr = 5'd4;
      @(posedge clk); #1; chk("sb_cnt2", 32'(busy_cnt), 32'd2);
      @(negedge clk); alloc_addr = 5'd3;
      @(posedge clk); #1; chk("sb_cnt3", 32'(busy_cnt), 32'd2);
      @(negedge clk); alloc_en = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
      #1;
      chk("sb_rdy3", 32'(rd_ready1), 32'd0);
      chk("sb_rdy4", 32'(rd_ready2), 32'd0);
      @(negedge clk); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
      #1;
      chk("sb_wr_rdy3", 32'(rd_ready1), 32'd1);
      chk("sb_wr_d3",   rd_data1, 32'h33);
      @(posedge clk); #1; chk("sb_wr_cnt", 32'(busy_cnt), 32'd1);
      @(negedge clk); wr_en = 1'b0;
      #1;
      chk("sb_post_rdy3", 32'(rd_ready1), 32'd1);
      chk("sb_post_d3",   rd_data1, 32'h33);
      chk("sb_post_rdy4", 32'(rd_ready2), 32'd0);

      // 5. Simultaneous alloc + write
      @(negedge clk); alloc_en = 1'b1; alloc_addr = 5'd7;
      @(posedge clk); #1; chk("sim_cnt_a7", 32'(busy_cnt), 32'd2);
      @(negedge clk); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
      @(posedge clk); #1; chk("sim_cnt_same", 32'(busy_cnt), 32'd2);
      @(negedge clk); wr_en = 1'b0; alloc_en = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd8;
      #1;
      chk("sim_d7",   rd_data1, 32'h1234);
      chk("sim_rdy7", 32'(rd_ready1), 32'd0);
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 5'd8; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h5555;
      @(posedge clk); #1; chk("sim_cnt_diff", 32'(busy_cnt), 32'd2);
      @(negedge clk); wr_en = 1'b0; alloc_en = 1'b0;
      #1;
      chk("sim_d7b",   rd_data1, 32'h5555);
      chk("sim_rdy7b", 32'(rd_ready1), 32'd1);
      chk("sim_rdy8",  32'(rd_ready2), 32'd0);
      chk("sim_d8",    rd_data2, 32'd16);

      // 6. Async reset mid-cycle with 3 busy (4, 8, 9)
      @(negedge clk); alloc_en = 1'b1; alloc_addr = 5'd9;
      @(posedge clk); #1; chk("ar_cnt3", 32'(busy_cnt), 32'd3);
      @(negedge clk);
      alloc_en = 1'b1; alloc_addr = 5'd10; wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hFF;
      rd_addr1 = 5'd2; rd_addr2 = 5'd8;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_cnt0",  32'(busy_cnt), 32'd0);
      chk("ar_d2",    rd_data1, 32'd0);
      chk("ar_d8",    rd_data2, 32'd0);
      chk("ar_rdy8",  32'(rd_ready2), 32'd1);
      @(posedge clk); #1;
      chk("ar_hold_cnt", 32'(busy_cnt), 32'd0);
      @(negedge clk); wr_en = 1'b0; alloc_en = 1'b0; rd_addr1 = 5'd10; rd_addr2 = 5'd11;
      #1;
      chk("ar_rdy10", 32'(rd_ready1), 32'd1);
      chk("ar_d11",   rd_data2, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ar_final_cnt", 32'(busy_cnt), 32'd0);
      chk("ar_final_d11", rd_data2, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

`default_nettype wire
